// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the MAC operand feeder: the feeder state encoding,
// the default operand width used across the MAC array, and a small sizing helper.
package mac_operand_feeder_pkg;

  // Operand width of the downstream MAC cell; the feeder defaults to it.
  localparam int MAC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FEED   = 2'd1,
    FINISH = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  // Bits needed for a counter that must hold 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Handshake bundle between the edge buffers, the operand feeder and the MAC cell.
// The slave modport is the feeder's view; the master modport is everything around it.
interface mac_operand_feeder_if
  import mac_operand_feeder_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W
);

  logic [DATA_W-1:0] s_a_data;
  logic              s_a_valid;
  logic              s_a_ready;
  logic [DATA_W-1:0] s_b_data;
  logic              s_b_valid;
  logic              s_b_ready;

  logic [DATA_W-1:0] A_out;
  logic [DATA_W-1:0] B_out;
  logic              A_waiting;
  logic              B_waiting;
  logic              A_finished;
  logic              B_finished;
  logic              A_ready;
  logic              B_ready;

  modport slave (
    input  s_a_data, s_a_valid, s_b_data, s_b_valid, A_ready, B_ready,
    output s_a_ready, s_b_ready, A_out, B_out,
           A_waiting, B_waiting, A_finished, B_finished
  );

  modport master (
    output s_a_data, s_a_valid, s_b_data, s_b_valid, A_ready, B_ready,
    input  s_a_ready, s_b_ready, A_out, B_out,
           A_waiting, B_waiting, A_finished, B_finished
  );

endinterface

// File: rtl/mac_operand_feeder_fifo.sv
// Small operand FIFO for one stream. Pointers carry one extra wrap bit so full and
// empty come from a plain compare. push_ready is a registered copy of !full, so a
// full FIFO refuses a push even when a pop happens in the same cycle.
module mac_operand_feeder_fifo
  import mac_operand_feeder_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ready = ready_q;
  assign do_push    = push_valid && ready_q;
  assign do_pop     = pop && !empty;

  // Next pointers, storage write, and the next-cycle ready from the updated occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  // Pointer and ready registers; ready stays low while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: it is only read through the pointers, which are reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Per-MAC operand sequencer: buffers the A and B streams, presents matched pairs to
// the MAC with waiting/ready, and raises finished for FIN_HOLD cycles after every
// K consumed pairs, followed by one quiet cycle before the next dot product.
// Optional build macro FEEDER_ZERO_SKIP_EN: pairs with a zero operand are popped
// internally without being presented, but still count toward K.
module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter int DATA_W   = MAC_DATA_W,
  parameter int K        = 8,
  parameter int DEPTH    = 4,
  parameter int FIN_HOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  mac_operand_feeder_if.slave      bus,
  output logic [$clog2(K+1)-1:0]   elem_cnt,
  output logic                     busy
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int FIN_W = cnt_width(FIN_HOLD - 1);
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(K - 1);
  localparam logic [FIN_W-1:0] FIN_LAST  = FIN_W'(FIN_HOLD - 1);

  feeder_state_t     state_q, state_d;
  logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
  logic [FIN_W-1:0]  fin_cnt_q, fin_cnt_d;

  logic [DATA_W-1:0] head_a, head_b;
  logic              a_empty, b_empty, a_full, b_full;
  logic              a_push, b_push;
  logic              pair_avail, zero_pair;
  logic              waiting, finished, pop;

  mac_operand_feeder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .push_data  (bus.s_a_data),
    .push_valid (bus.s_a_valid),
    .push_ready (bus.s_a_ready),
    .pop        (pop),
    .head       (head_a),
    .empty      (a_empty),
    .full       (a_full)
  );

  mac_operand_feeder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .push_data  (bus.s_b_data),
    .push_valid (bus.s_b_valid),
    .push_ready (bus.s_b_ready),
    .pop        (pop),
    .head       (head_b),
    .empty      (b_empty),
    .full       (b_full)
  );

  assign a_push     = bus.s_a_valid && bus.s_a_ready && !a_full;
  assign b_push     = bus.s_b_valid && bus.s_b_ready && !b_full;
  assign pair_avail = !a_empty && !b_empty;

  // Zero-operand detection on the head pair (constant low unless zero-skip is built in).
`ifdef FEEDER_ZERO_SKIP_EN
  assign zero_pair = pair_avail && ((head_a == '0) || (head_b == '0));
`else
  assign zero_pair = 1'b0;
`endif

  // Sequencing: present pairs in FEED, count consumes, hold finished, then one quiet cycle.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    fin_cnt_d  = fin_cnt_q;
    waiting    = 1'b0;
    finished   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_push || b_push || !a_empty || !b_empty) begin
          state_d = FEED;
        end
      end
      FEED: begin
        if (pair_avail) begin
          if (zero_pair) begin
            pop = 1'b1;
          end else begin
            waiting = 1'b1;
            pop     = bus.A_ready && bus.B_ready;
          end
        end
        if (pop) begin
          if (elem_cnt_q == LAST_ELEM) begin
            elem_cnt_d = '0;
            fin_cnt_d  = '0;
            state_d    = FINISH;
          end else begin
            elem_cnt_d = elem_cnt_q + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        finished = 1'b1;
        if (fin_cnt_q == FIN_LAST) begin
          state_d = DRAIN;
        end else begin
          fin_cnt_d = fin_cnt_q + FIN_W'(1);
        end
      end
      DRAIN: begin
        // Anything buffered sends us back to FEED; a lone operand would bounce
        // through IDLE straight back to FEED anyway.
        if (a_push || b_push || !a_empty || !b_empty) begin
          state_d = FEED;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, element and finished-hold registers; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      fin_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      fin_cnt_q  <= fin_cnt_d;
    end
  end

  assign bus.A_waiting  = waiting;
  assign bus.B_waiting  = waiting;
  assign bus.A_finished = finished;
  assign bus.B_finished = finished;
  assign bus.A_out      = waiting ? head_a : '0;
  assign bus.B_out      = waiting ? head_b : '0;
  assign elem_cnt       = elem_cnt_q;
  assign busy           = (state_q != IDLE);

endmodule
